// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Bundles the signals between the fetch stage and its
//                neighbours: the instruction ROM, the hazard and redirect
//                sources, and the IF/ID register it feeds.
//                  imem_addr     - word address to the instruction ROM
//                  imem_data     - instruction returned by the ROM
//                  stall         - freeze the PC and IF/ID
//                  branch_taken  - redirect to branch_target (top priority)
//                  branch_target - branch destination byte address
//                  jump          - redirect to jump_target
//                  jump_target   - jump destination byte address
//                  pc            - current PC register
//                  if_instr      - registered instruction
//                  if_pc4        - registered PC+4 of if_instr
//                  if_valid      - if_instr is real (0 = bubble)
//                  if_oob        - if_instr was fetched from outside the ROM
//                Modport slave is the fetch unit. Modport master is the
//                surrounding pipeline and ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int IMEM_AW = 6
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_data;
    logic               stall;
    logic               branch_taken;
    logic [31:0]        branch_target;
    logic               jump;
    logic [31:0]        jump_target;
    logic [31:0]        pc;
    logic [31:0]        if_instr;
    logic [31:0]        if_pc4;
    logic               if_valid;
    logic               if_oob;

    modport slave (
        output imem_addr,
        input  imem_data,
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  jump,
        input  jump_target,
        output pc,
        output if_instr,
        output if_pc4,
        output if_valid,
        output if_oob
    );

    modport master (
        input  imem_addr,
        output imem_data,
        output stall,
        output branch_taken,
        output branch_target,
        output jump,
        output jump_target,
        input  pc,
        input  if_instr,
        input  if_pc4,
        input  if_valid,
        input  if_oob
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage. Owns the PC, addresses the
//                word-addressed instruction ROM, and captures the returned
//                instruction into the IF/ID register.
//                Next-PC priority: reset > branch > jump > stall > PC+4.
//  Ports       : clk   - system clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - fetch_unit_if.slave (ROM, control, IF/ID outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 6
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    fetch_unit_if.slave bus
);

    logic [31:0] r_pc;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc4;
    logic        r_if_valid;
    logic        r_if_oob;

    logic [31:0] w_pc_plus4;
    logic        w_oob;

    always_comb begin
        w_pc_plus4 = r_pc + 32'd4;
        // Any PC bit above the ROM word-address field means the ROM index
        // has aliased.
        w_oob      = (r_pc[31:IMEM_AW+2] != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_if_instr <= 32'h0000_0000;
            r_if_pc4   <= 32'h0000_0000;
            r_if_valid <= 1'b0;
            r_if_oob   <= 1'b0;
        end else if (bus.branch_taken || bus.jump) begin
            // Redirect squashes the wrong-path fetch even while stalled.
            // The branch wins when both redirects are raised together.
            r_pc       <= bus.branch_taken ? (bus.branch_target & ~32'h3)
                                           : (bus.jump_target   & ~32'h3);
            r_if_instr <= 32'h0000_0000;
            r_if_pc4   <= 32'h0000_0000;
            r_if_valid <= 1'b0;
            r_if_oob   <= 1'b0;
        end else if (!bus.stall) begin
            r_pc       <= w_pc_plus4;
            r_if_instr <= bus.imem_data;
            r_if_pc4   <= w_pc_plus4;
            r_if_valid <= 1'b1;
            r_if_oob   <= w_oob;
        end
    end

    assign bus.imem_addr = r_pc[IMEM_AW+1:2];
    assign bus.pc        = r_pc;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc4    = r_if_pc4;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_oob    = r_if_oob;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the program counter and drives the word-addressed instruction ROM. It computes the next PC from sequential, branch and jump sources, and honours stall and redirect requests. It captures the returned instruction into an IF/ID pipeline register with a valid bit. It sits directly upstream of the instruction memory and directly feeds the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- IMEM_AW, 6, instruction-memory word-address width; the ROM sees PC[IMEM_AW+1:2].
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low: sampled on the rising edge of clk; while 0 at an edge, all state takes reset values.
- imem_addr  out  IMEM_AW  word address to instruction memory = pc[IMEM_AW+1:2], combinational from the PC register.
- imem_data  in  32  instruction returned combinationally by instruction memory for imem_addr.
- stall  in  1  decode/hazard hold request: freeze PC and IF/ID.
- branch_taken  in  1  redirect to branch_target this cycle.
- branch_target  in  32  branch destination byte address.
- jump  in  1  redirect to jump_target this cycle.
- jump_target  in  32  jump destination byte address.
- pc  out  32  current PC register.
- if_instr  out  32  registered instruction to decode.
- if_pc4  out  32  registered PC+4 of if_instr.
- if_valid  out  1  if_instr is a real instruction; 0 means bubble.
- if_oob  out  1  if_instr was fetched from a PC outside the ROM range.

## Operation
- pc_plus4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- Next-PC priority, highest first: rst_n=0 -> RESET_PC; branch_taken -> {branch_target[31:2],2'b00}; jump -> {jump_target[31:2],2'b00}; stall -> pc (hold); otherwise pc_plus4.
- Target bits [1:0] are always forced to 0. No misalignment fault is raised.
- IF/ID update, same priority:
  - reset -> if_instr=0, if_pc4=0, if_valid=0, if_oob=0.
  - redirect (branch_taken or jump) -> flush: if_instr=32'h0000_0000 (nop), if_pc4=0, if_valid=0, if_oob=0.
  - stall -> hold all IF/ID fields.
  - else -> if_instr=imem_data, if_pc4=pc_plus4, if_valid=1, if_oob=(pc[31:IMEM_AW+2]!=0).
- Redirect overrides stall. The redirect originates in a later stage and the wrong-path fetch must be squashed even while decode is stalled.
- branch_taken and jump both high: the branch wins and jump is ignored.
- Out-of-range PC: the ROM address aliases (wraps modulo 2^IMEM_AW words). The instruction is still delivered with if_valid=1, and if_oob=1 flags it for the downstream exception logic.
- The block holds no other state. There is no prefetch buffer, and each cycle fetches at most one instruction.

## Timing
- Reset values: pc=RESET_PC, if_instr=0, if_pc4=0, if_valid=0, if_oob=0. imem_addr=RESET_PC[IMEM_AW+1:2].
- First edge after rst_n rises: IF/ID captures ROM[RESET_PC>>2] with if_valid=1, and pc becomes RESET_PC+4.
- Fetch latency: an instruction at PC p appears on if_instr one edge after pc=p, provided there is no stall or redirect at that edge.
- Redirect asserted in cycle n: pc=target after edge n and if_valid=0 after edge n. The target instruction appears on if_instr after edge n+1. This costs a one-bubble penalty.
- Stall held for k cycles: pc and IF/ID unchanged for k edges. Fetch resumes at the first edge with stall=0, and no instruction is lost or duplicated.
- Reset asserted mid-stream (including during stall or redirect) wins at that edge. All in-flight state is discarded.
- Throughput: one instruction per cycle with no stall or redirect.

## Test plan
- Reset, then ROM[0..3]=20020005, 2003000c, 2067fff7, 00e22025 with no stall -> if_instr sequence 20020005, 2003000c, 2067fff7, 00e22025 on consecutive cycles; if_pc4 = 4, 8, 12, 16; if_valid=1 throughout.
- stall=1 for 3 cycles while pc=8 -> pc stays 8 and if_instr stays 2003000c for 3 edges. After release, next if_instr=2067fff7 with if_pc4=12.
- branch_taken=1, branch_target=40 at pc=24 -> next edge pc=40, if_valid=0, if_instr=0. Following edge if_instr=ROM[10], if_pc4=44.
- branch_taken=1 (target 36), jump=1 (target 68) and stall=1 in the same cycle -> pc=36, if_valid=0, and the jump is ignored.
- jump_target=32'h0000_0107 -> pc=32'h0000_0104, imem_addr=1 (aliased), and the next fetched instruction has if_oob=1, if_valid=1.
- rst_n=0 for one edge while stall=1 and pc=52 -> pc=RESET_PC, all IF/ID outputs 0. After release, fetch restarts at ROM[0].
